// File: rtl/psg_write_arbiter.sv
// psg_write_arbiter: shares the PSG byte write port between the 68k bridge
// (port 0) and the Z80 bridge (port 1). Accepted bytes go through a shared
// FIFO and are replayed as single-cycle nWE/nCE strobes paced by PSG READY.
// A tone latch byte locks arbitration to its sender until the matching data
// byte arrives or the lock times out.
module psg_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          req0_valid,
  input  logic [7:0]                    req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [7:0]                    req1_data,
  output logic                          req1_ready,
  input  logic                          psg_ready,
  output logic                          psg_nWE,
  output logic                          psg_nCE,
  output logic [7:0]                    psg_D,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LT_LAST  = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STROBE, RECOVER} eng_state_e;

  eng_state_e state_q, state_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rr_q, rr_d;

  logic          nwe_q, nwe_d;
  logic          nce_q, nce_d;
  logic [7:0]    dout_q, dout_d;

  logic          full, pop, room;
  logic          gnt0, gnt1, push, push_port, is_latch;
  logic [7:0]    push_data;

  assign full = (count_q == FULL_CNT);
  assign pop  = (state_q == IDLE) && (count_q != '0) && psg_ready;
  // A full FIFO can still take a byte when the engine pops in the same cycle.
  assign room = !full || pop;

  // Grant selection: lock owner first, otherwise single requester or round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    rr_d = rr_q;
    if (room) begin
      if (lock_q) begin
        if (owner_q) gnt1 = req1_valid;
        else         gnt0 = req0_valid;
      end else if (req0_valid && req1_valid) begin
        gnt0 = !rr_q;
        gnt1 = rr_q;
        rr_d = !rr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign push       = gnt0 || gnt1;
  assign push_port  = gnt1;
  assign push_data  = gnt1 ? req1_data : req0_data;
  assign is_latch   = push_data[7] && !push_data[4] && (push_data[6:5] != 2'b11);

  // Pair lock: armed by a tone latch, released by the owner's next byte or timeout.
  always_comb begin
    lock_d     = lock_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (push && is_latch) begin
      lock_d     = 1'b1;
      owner_d    = push_port;
      lock_cnt_d = '0;
    end else if (lock_q) begin
      if (push) begin
        lock_d     = 1'b0;
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LT_LAST) begin
        lock_d     = 1'b0;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end
  end

  // FIFO pointer, occupancy and storage update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write engine next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = STROBE;
      STROBE:  state_d = RECOVER;
      RECOVER: if (psg_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write engine strobe outputs; data holds until the next pop.
  always_comb begin
    nwe_d  = 1'b1;
    nce_d  = 1'b1;
    dout_d = dout_q;
    if (state_q == IDLE && pop) begin
      nwe_d  = 1'b0;
      nce_d  = 1'b0;
      dout_d = mem_q[rd_ptr_q];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      lock_cnt_q <= '0;
      rr_q       <= 1'b0;
      nwe_q      <= 1'b1;
      nce_q      <= 1'b1;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rr_q       <= rr_d;
      nwe_q      <= nwe_d;
      nce_q      <= nce_d;
      dout_q     <= dout_d;
    end
  end

  // FIFO storage; contents are discarded on reset through the pointers.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign psg_nWE    = nwe_q;
  assign psg_nCE    = nce_q;
  assign psg_D      = dout_q;
  assign fifo_count = count_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Directed bench for psg_write_arbiter: a vector table for arbitration and
// FIFO fill behaviour, plus sequences for strobe timing, contention, pair
// atomicity, lock timeout, backpressure and reset during a write.
module tb_psg_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LT    = 15;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       psg_ready, psg_nWE, psg_nCE, busy;
  logic [7:0] psg_D;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  psg_write_arbiter #(.FIFO_DEPTH(DEPTH), .LOCK_TIMEOUT(LT)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .psg_ready(psg_ready), .psg_nWE(psg_nWE), .psg_nCE(psg_nCE), .psg_D(psg_D),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } strobe_t;

  strobe_t    slog[$];
  int         low_samples = 0;
  logic [7:0] expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // PSG-side observer: every low nWE sample is one strobe cycle.
  always @(negedge CLK) begin
    if (psg_nWE === 1'b0) begin
      slog.push_back('{cyc, psg_D});
      low_samples++;
      chk("strobe_nce", psg_nCE, 1'b0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    tick();
    RST = 1'b0;
    slog.delete();
    low_samples = 0;
  endtask

  task automatic drain(input string nm, input int maxc);
    for (int k = 0; k < maxc && busy; k++) tick();
    chk(nm, busy, 1'b0);
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, slog.size(), expq.size());
    chk({nm, "_width"}, low_samples, expq.size());
    for (int i = 0; i < expq.size() && i < slog.size(); i++)
      chk($sformatf("%s_d%0d", nm, i), slog[i].d, expq[i]);
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       pr;
    logic       r0;
    logic       r1;
    logic [2:0] cnt;
    logic       nwe;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] bp[5];

  initial begin
    int acc, first, idx, nlow;
    logic [3:0] gbits;
    int ngr, i0, i1;

    // v0 d0 v1 d1 psg_ready | exp r0 r1 fifo_count nWE(after edge)
    vecs[0] = '{1'b1, 8'h90, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1};
    vecs[1] = '{1'b1, 8'h91, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1};
    vecs[3] = '{1'b1, 8'h85, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1};
    vecs[4] = '{1'b1, 8'h12, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[5] = '{1'b1, 8'h12, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0};
    bp[0] = 8'h01; bp[1] = 8'h02; bp[2] = 8'h03; bp[3] = 8'h04; bp[4] = 8'h05;

    psg_ready = 1'b1;
    @(negedge CLK);
    do_reset();

    // Reset state
    chk("rst_nwe", psg_nWE, 1'b1);
    chk("rst_nce", psg_nCE, 1'b1);
    chk("rst_d", psg_D, 8'h00);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_busy", busy, 1'b0);

    // Vector table: arbitration, lock, full FIFO and pop-while-full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1;
      psg_ready  = vecs[i].pr;
      #1;
      chk($sformatf("vec%0d_r0", i), req0_ready, vecs[i].r0);
      chk($sformatf("vec%0d_r1", i), req1_ready, vecs[i].r1);
      tick();
      chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].cnt);
      chk($sformatf("vec%0d_nwe", i), psg_nWE, vecs[i].nwe);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; psg_ready = 1'b1;
    drain("vec_drain", 60);
    expq.delete();
    expq.push_back(8'h90); expq.push_back(8'hB0); expq.push_back(8'hB1);
    expq.push_back(8'h85); expq.push_back(8'h12); expq.push_back(8'hB2);
    check_log("vec_log");

    // Single write: strobe two cycles after acceptance, one cycle wide
    do_reset();
    psg_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h8A;
    #1;
    chk("single_ready", req0_ready, 1'b1);
    acc = cyc;
    tick();
    req0_valid = 1'b0;
    drain("single_busy", 20);
    expq.delete(); expq.push_back(8'h8A);
    check_log("single_log");
    if (slog.size() > 0) chk("single_lat", slog[0].cyc, acc + 2);

    // Contention: round-robin alternation
    do_reset();
    psg_ready = 1'b1;
    i0 = 0; i1 = 0; ngr = 0; gbits = '0;
    for (int k = 0; k < 20 && (i0 < 2 || i1 < 2); k++) begin
      req0_valid = (i0 < 2); req0_data = (i0 == 0) ? 8'h90 : 8'h91;
      req1_valid = (i1 < 2); req1_data = (i1 == 0) ? 8'hB0 : 8'hB1;
      #1;
      if (req0_ready) begin gbits = {gbits[2:0], 1'b0}; i0++; ngr++; end
      if (req1_ready) begin gbits = {gbits[2:0], 1'b1}; i1++; ngr++; end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_ngrant", ngr, 4);
    chk("cont_order", gbits, 4'b0101);
    drain("cont_busy", 40);
    expq.delete();
    expq.push_back(8'h90); expq.push_back(8'hB0);
    expq.push_back(8'h91); expq.push_back(8'hB1);
    check_log("cont_log");

    // Pair atomicity: port 1 held off until port 0's data byte
    do_reset();
    psg_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h85;
    req1_valid = 1'b1; req1_data = 8'hA3;
    #1;
    chk("pair_latch_r0", req0_ready, 1'b1);
    chk("pair_latch_r1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("pair_hold%0d", k), req1_ready, 1'b0);
      tick();
    end
    req0_valid = 1'b1; req0_data = 8'h12;
    #1;
    chk("pair_data_r0", req0_ready, 1'b1);
    chk("pair_data_r1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("pair_release", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    drain("pair_busy", 40);
    expq.delete();
    expq.push_back(8'h85); expq.push_back(8'h12); expq.push_back(8'hA3);
    check_log("pair_log");

    // Lock timeout: orphaned latch releases arbitration
    do_reset();
    psg_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h85;
    req1_valid = 1'b1; req1_data = 8'hA3;
    #1;
    chk("to_latch", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (req1_ready) begin
        first = k;
        tick();
        break;
      end
      tick();
    end
    req1_valid = 1'b0;
    chk("to_grant_cycle", first, LT + 1);
    drain("to_busy", 40);

    // Backpressure: READY low fills the FIFO, then drains at 3-cycle spacing
    do_reset();
    psg_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      req1_valid = 1'b1; req1_data = bp[idx];
      #1;
      if (req1_ready) idx++;
      tick();
    end
    chk("bp_accepted", idx, 4);
    chk("bp_count", fifo_count, 3'd4);
    req1_data = bp[idx];
    #1;
    chk("bp_full_ready", req1_ready, 1'b0);
    psg_ready = 1'b1;
    #1;
    chk("bp_fifth", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    drain("bp_busy", 60);
    expq.delete();
    for (int i = 0; i < 5; i++) expq.push_back(bp[i]);
    check_log("bp_log");
    for (int i = 1; i < slog.size(); i++)
      chk($sformatf("bp_space%0d", i), slog[i].cyc - slog[i-1].cyc, 3);

    // Reset during STROBE with three bytes still queued
    do_reset();
    psg_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_data = 8'h21 + 8'(k);
      tick();
    end
    req0_valid = 1'b0;
    psg_ready = 1'b1;
    tick();
    chk("mid_strobe", psg_nWE, 1'b0);
    chk("mid_count", fifo_count, 3'd3);
    RST = 1'b1;
    tick();
    chk("mid_rst_nwe", psg_nWE, 1'b1);
    chk("mid_rst_nce", psg_nCE, 1'b1);
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_d", psg_D, 8'h00);
    RST = 1'b0;
    nlow = low_samples;
    repeat (10) tick();
    chk("mid_no_strobe", low_samples, nlow);
    chk("mid_idle_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
